// File: rtl/restoring_div_ctrl.sv
// Control FSM and remainder datapath for the 4-bit restoring divider around an external A/Q shift stage.
// Optional: define DIV_BY_ZERO_DETECT_EN to short-circuit zero divisors straight to DONE.
module restoring_div_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend_in,
    input  logic [3:0] divisor_in,
    input  logic [4:0] shift_out,
    output logic [5:0] A,
    output logic [3:0] dividend,
    output logic       shift_left_enable,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, CALC, DONE} state_t;

    state_t     state;
    logic [3:0] m_q;
    logic [1:0] cnt;
    logic [5:0] diff;
    logic [5:0] a_nxt;
    logic       qbit;

    // Trial subtraction on the freshly shifted {A, Q[3]}; a negative result restores.
    assign diff  = {1'b0, shift_out} - {2'b00, m_q};
    assign qbit  = ~diff[5];
    assign a_nxt = qbit ? diff : {1'b0, shift_out};

`ifdef DIV_BY_ZERO_DETECT_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            A                 <= '0;
            dividend          <= '0;
            m_q               <= '0;
            cnt               <= '0;
            quotient          <= '0;
            remainder         <= '0;
            shift_left_enable <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q             <= 1'b0;
`endif
        end else begin
            shift_left_enable <= 1'b0;
            done              <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        A        <= '0;
                        dividend <= dividend_in;
                        m_q      <= divisor_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
`ifdef DIV_BY_ZERO_DETECT_EN
                        if (divisor_in == 4'd0) begin
                            quotient  <= 4'hF;
                            remainder <= dividend_in;
                            dbz_q     <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dbz_q             <= 1'b0;
                            shift_left_enable <= 1'b1;
                            state             <= SHIFT;
                        end
`else
                        shift_left_enable <= 1'b1;
                        state             <= SHIFT;
`endif
                    end
                end
                SHIFT: state <= CALC;
                CALC: begin
                    A        <= a_nxt;
                    dividend <= {dividend[2:0], qbit};
                    if (cnt == 2'd3) begin
                        quotient  <= {dividend[2:0], qbit};
                        remainder <= a_nxt[3:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt               <= cnt + 2'd1;
                        shift_left_enable <= 1'b1;
                        state             <= SHIFT;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Directed bench for restoring_div_ctrl with a behavioural A/Q shift stage in the loop.
module tb_restoring_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend_in, divisor_in;
    logic [4:0] shift_out;
    logic [5:0] A;
    logic [3:0] dividend, quotient, remainder;
    logic       shift_left_enable, busy, done, div_by_zero;

    int n_applied = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    restoring_div_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .shift_out(shift_out), .A(A), .dividend(dividend),
        .shift_left_enable(shift_left_enable), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    // Shift stage: registers {A[3:0], Q[3]} on the SHIFT edge.
    always @(posedge clk) begin
        if (rst) shift_out <= '0;
        else if (shift_left_enable) shift_out <= {A[3:0], dividend[3]};
    end

    typedef struct {
        logic [3:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
        logic [9:0] sle_mask;
    } vec_t;

`ifdef DIV_BY_ZERO_DETECT_EN
    localparam logic Z_DBZ = 1'b1;
    localparam int   Z_LAT = 1;
    localparam logic [9:0] Z_MASK = 10'h000;
`else
    localparam logic Z_DBZ = 1'b0;
    localparam int   Z_LAT = 9;
    localparam logic [9:0] Z_MASK = 10'h0AA;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one division; returns results, latency to done, per-cycle shift strobe mask, busy/tail sanity.
    task automatic run_div(input logic [3:0] dvd, input logic [3:0] dvs,
                           output logic [3:0] q, output logic [3:0] r, output logic dbz,
                           output int lat, output logic [9:0] mask, output logic busy_ok,
                           output logic tail_ok);
        @(negedge clk);
        start = 1'b1; dividend_in = dvd; divisor_in = dvs;
        lat = 99; mask = '0; busy_ok = 1'b1; q = 'x; r = 'x; dbz = 'x; tail_ok = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (shift_left_enable && c < 10) mask[c] = 1'b1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c; q = quotient; r = remainder; dbz = div_by_zero;
                break;
            end
        end
        @(negedge clk);
        tail_ok = !busy && !done && quotient == q && remainder == r;
    endtask

    vec_t vecs[9];

    initial begin
        logic [3:0] q, r;
        logic       dbz, bok, tok, seen_done;
        int         lat;
        logic [9:0] mask;

        vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1,  1'b0,  9,     10'h0AA};
        vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0,  1'b0,  9,     10'h0AA};
        vecs[2] = '{4'd7,  4'd9, 4'd0,  4'd7,  1'b0,  9,     10'h0AA};
        vecs[3] = '{4'd10, 4'd0, 4'd15, 4'd10, Z_DBZ, Z_LAT, Z_MASK};
        vecs[4] = '{4'd0,  4'd5, 4'd0,  4'd0,  1'b0,  9,     10'h0AA};
        vecs[5] = '{4'd15, 4'd15,4'd1,  4'd0,  1'b0,  9,     10'h0AA};
        vecs[6] = '{4'd9,  4'd2, 4'd4,  4'd1,  1'b0,  9,     10'h0AA};
        vecs[7] = '{4'd14, 4'd4, 4'd3,  4'd2,  1'b0,  9,     10'h0AA};
        vecs[8] = '{4'd8,  4'd7, 4'd1,  4'd1,  1'b0,  9,     10'h0AA};

        rst = 1'b1; start = 1'b0; dividend_in = '0; divisor_in = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {A, dividend, shift_left_enable, busy, done, quotient, remainder, div_by_zero}, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_div(vecs[i].dvd, vecs[i].dvs, q, r, dbz, lat, mask, bok, tok);
            check($sformatf("v%0d_quotient", i), q, vecs[i].q);
            check($sformatf("v%0d_remainder", i), r, vecs[i].r);
            check($sformatf("v%0d_dbz", i), dbz, vecs[i].dbz);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_shift_mask", i), mask, vecs[i].sle_mask);
            check($sformatf("v%0d_busy", i), bok, 1);
            check($sformatf("v%0d_idle_after", i), tok, 1);
        end

        // Exhaustive nonzero-divisor sweep against / and %.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a[3:0], b[3:0], q, r, dbz, lat, mask, bok, tok);
                check($sformatf("sweep_%0d_%0d_q", a, b), q, a / b);
                check($sformatf("sweep_%0d_%0d_r", a, b), r, a % b);
            end
        end

        // start re-asserted in C4 and in DONE is ignored; start in C10 is accepted.
        @(negedge clk);
        start = 1'b1; dividend_in = 4'd13; divisor_in = 4'd3;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4)  begin start = 1'b1; dividend_in = 4'd2; divisor_in = 4'd1; end
            if (c == 9) begin
                check("ign_done_c9", done, 1);
                check("ign_q", quotient, 4);
                check("ign_r", remainder, 1);
                start = 1'b1; dividend_in = 4'd5; divisor_in = 4'd1;
            end
            if (c == 10) begin
                check("ign_idle_c10", {busy, done}, 0);
                start = 1'b1; dividend_in = 4'd9; divisor_in = 4'd2;
            end
            if (c == 11) check("accept_c10_busy", busy, 1);
        end
        lat = 99;
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        check("c10_latency", lat, 9);
        check("c10_q", quotient, 4);
        check("c10_r", remainder, 1);
        @(negedge clk);

        // Reset in C5 aborts the division and clears the held results.
        @(negedge clk);
        start = 1'b1; dividend_in = 4'd15; divisor_in = 4'd2;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {A, dividend, shift_left_enable, busy, done, quotient, remainder, div_by_zero}, 0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("rst_no_done", seen_done, 0);
        run_div(4'd9, 4'd2, q, r, dbz, lat, mask, bok, tok);
        check("post_rst_q", q, 4);
        check("post_rst_r", r, 1);
        check("post_rst_latency", lat, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule

// File: doc/restoring_div_ctrl.md
# restoring_div_ctrl

Control and remainder datapath for the 4-bit restoring divider. Sits around the A/Q shift-register stage: drives its `A`, `dividend` and `shift_left_enable` inputs, consumes its `shift_out`, and performs the per-iteration trial subtraction and restore. It also shifts the quotient bits into Q and presents the final quotient and remainder with a start/busy/done handshake.

## Interface
Parameters: none (widths fixed at 4-bit operands).

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE.
- `dividend_in` input 4: unsigned dividend, captured on accepted `start`.
- `divisor_in` input 4: unsigned divisor, captured on accepted `start`.
- `shift_out` input 5: shifted {A[3:0], Q[3]} from the shift-register stage.
- `A` output 6: partial remainder to the shift stage; `A[5:4]` always 0.
- `dividend` output 4: Q register (dividend bits shifting out, quotient bits shifting in).
- `shift_left_enable` output 1: one-cycle shift strobe to the shift stage.
- `busy` output 1: high from the cycle after `start` acceptance until `done`, inclusive.
- `done` output 1: one-cycle pulse; `quotient`/`remainder` valid.
- `quotient` output 4: result, held until next accepted `start`.
- `remainder` output 4: result, held until next accepted `start`.
- `div_by_zero` output 1: divisor-zero flag, held with results.

## Operation
- States: IDLE, SHIFT, CALC, DONE. 2-bit iteration counter `cnt`, divisor register M[3:0].
- IDLE: `start`=1 → A<=0, Q<=`dividend_in`, M<=`divisor_in`, cnt<=0, clear `div_by_zero`, go SHIFT. `start`=0 → stay.
- SHIFT: `shift_left_enable`=1 for exactly this cycle; go CALC.
- CALC: diff[5:0] = {1'b0,`shift_out`} − {2'b00,M}.
  - diff[5]=1 (negative): A<={1'b0,`shift_out`} (restore), qbit=0.
  - diff[5]=0: A<=diff, qbit=1.
  - Q<={Q[2:0],qbit}. cnt=3 → latch `quotient`<={Q[2:0],qbit} and `remainder`<=new A[3:0], go DONE; else cnt<=cnt+1, go SHIFT.
- DONE: `done`=1, go IDLE.
- `start` outside IDLE (including DONE) is ignored; no queuing.
- Remainder < M ≤ 15, so A never exceeds 4 significant bits.
- Reset: state IDLE; A, Q, M, cnt, `quotient`, `remainder` = 0; `shift_left_enable`, `busy`, `done`, `div_by_zero` = 0. Reset mid-division aborts with no `done`; results read 0.

## Timing
- C0: `start` accepted in IDLE. C1..C8: four SHIFT/CALC pairs, with SHIFT in C1, C3, C5, C7. C9: DONE, `done`=1. Results are visible in C9 and held afterwards.
- The shift stage registers on the SHIFT edge. `shift_out` is consumed only in the following CALC cycle. `A`/`dividend` are stable during SHIFT.
- `busy`=1 in C1..C9. The earliest next `start` is accepted in C10.
- All outputs are registered. There is no combinational path from `start` to any output.

## Configuration
- `DIV_BY_ZERO_DETECT_EN` defined: in IDLE, an accepted `start` with `divisor_in`=0 skips the iterations.
  - Go directly to DONE. `done` is in C1.
  - `quotient`=4'hF, `remainder`=`dividend_in`, `div_by_zero`=1.
  - `shift_left_enable` is never asserted.
- Not defined: `div_by_zero` is tied 0. A zero divisor runs the normal 9-cycle sequence. This naturally yields `quotient`=4'hF and `remainder`=`dividend_in`.

## Test plan
- 13 ÷ 3 (with shift stage instantiated) → `done` in C9, `quotient`=4, `remainder`=1; `shift_left_enable` high in C1, C3, C5, C7 only.
- 15 ÷ 1 → `quotient`=15, `remainder`=0. 7 ÷ 9 → `quotient`=0, `remainder`=7. Exhaustive 16×15 nonzero-divisor sweep matches `/` and `%`.
- 10 ÷ 0 with `DIV_BY_ZERO_DETECT_EN` → `done` in C1, `quotient`=15, `remainder`=10, `div_by_zero`=1. Without the macro → `done` in C9, same quotient/remainder, `div_by_zero`=0.
- `start` re-asserted in C4 and in the DONE cycle → ignored; results are those of the first operands; `start` in C10 is accepted.
- `rst` in C5 → next cycle IDLE, all outputs 0, no `done`. A fresh 9 ÷ 2 then yields `quotient`=4, `remainder`=1.
